led_bit_serializer: RTL
=======================

Name: led_bit_serializer

Overview:
- Downstream output stage of the LEDLines top level: one instance drives each LED_SIGn line.
- Accepts GRB pixel words over a valid/ready handshake and serialises them MSB-first onto a single-wire WS2812-style line using pulse-width bit coding.
- At frame end it holds the line low for the latch interval.
- Runs on the 50 MHz system clock; all timing is in clock cycles (20 ns).

Parameters:
- DATA_WIDTH, 24, bits per pixel word, shifted MSB first.
- T_BIT, 63, cycles per bit period (1.26 us).
- T0H, 20, high cycles for a 0 bit (0.40 us).
- T1H, 40, high cycles for a 1 bit (0.80 us).
- T_LATCH, 2600, low cycles after the last word of a frame (52 us).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- PIX_DATA  in  DATA_WIDTH  pixel word.
- PIX_LAST  in  1  qualifies PIX_DATA as the final word of a frame.
- PIX_VALID  in  1  word available.
- PIX_READY  out  1  block accepts a word this cycle.
- LED_SIG  out  1  serial LED line, registered.
- BUSY  out  1  high in any state other than IDLE.
- UNDERRUN  out  1  one-cycle pulse when the stream starves mid-frame.

Behaviour:
- Reset:
  - CLK is the single clock; RST_N is asynchronous, active-low.
  - In reset: state IDLE, LED_SIG=0, BUSY=0, UNDERRUN=0, all counters and the shift register 0.
  - PIX_READY=0 while RST_N is low and for the first cycle after release, via an internal registered rst_done flag.
- Acceptance: a word is accepted on a rising edge with PIX_VALID & PIX_READY. PIX_DATA and PIX_LAST are captured into a shift register and last flag.
- PIX_READY is combinational and equals rst_done & ((state==IDLE) | (state==LOW & bit_idx==DATA_WIDTH-1 & cyc==T_BIT-1 & !last_q)).
- States:
  - IDLE: LED_SIG=0. On accept, go to HIGH with cyc=0 and bit_idx=0.
  - HIGH: LED_SIG=1. Leave when cyc reaches thi-1, where thi=T1H if the current MSB is 1, else T0H. Then go to LOW.
  - LOW: LED_SIG=0. When cyc reaches T_BIT-1:
    - If bit_idx<DATA_WIDTH-1: shift left, bit_idx+1, go to HIGH.
    - If the word is finished and last_q=1: go to LATCH.
    - If the word is finished and a word is accepted this cycle: load it and go to HIGH directly (gapless, no idle cycle).
    - Otherwise: go to IDLE and pulse UNDERRUN for one cycle.
  - LATCH: LED_SIG=0, PIX_READY=0. Count T_LATCH cycles, then go to IDLE.
- Timing rules:
  - Latency: LED_SIG rises on the clock edge after the acceptance edge.
  - Each bit occupies exactly T_BIT cycles: LED_SIG high for T0H or T1H cycles, then low for the remainder.
- Counters: cyc is clog2(T_LATCH) bits wide and shared between bit timing and latch timing. bit_idx is clog2(DATA_WIDTH) bits wide.
- Boundary conditions:
  - PIX_VALID held with PIX_READY low: no acceptance, and PIX_DATA is not sampled.
  - PIX_LAST on a single-word frame: one word is sent, then LATCH.
  - An UNDERRUN frame is not latched by this block; the upstream logic owns recovery.
  - RST_N asserted mid-bit or mid-latch: LED_SIG drops to 0 asynchronously and the partially sent word is discarded.
  - Elaboration error if T1H>=T_BIT, T0H>=T1H, or T0H==0.

Optional Feature:
- Macro: LED_BIT_SERIALIZER_INV_EN.
- With the macro defined: LED_SIG is inverted at the output register, for inverting level shifters. The line is 1 in reset, IDLE and LATCH, and every pulse polarity is flipped. Timing is unchanged.
- Without the macro: polarity is as described in Behaviour.

Decomposition:
- Shared package ledlines_pkg holds:
  - DATA_WIDTH (24);
  - timing constants T_BIT, T0H, T1H, T_LATCH, derived for 50 MHz;
  - the state enum encoding IDLE/HIGH/LOW/LATCH.
- No sub-module: the FSM, counters and shift register fit in one module.
- TOP instantiates four copies, one per LED_SIG0..3.

Test Plan:
- Single word 0xFF0000 with PIX_LAST=1 after reset: first 8 bits are 40 high / 23 low cycles, next 16 are 20 high / 43 low; then 2600 low cycles; BUSY falls and PIX_READY returns on the following cycle.
- Three words 0x000001, 0x800000, 0xAAAAAA with valid held high, last on word 3: exactly 72 contiguous bit periods, no idle cycle between words, and PIX_READY high only in the final cycle of words 1 and 2.
- Two words with a 5-cycle valid gap after word 1, no last: UNDERRUN pulses once at the end of word 1, the line stays low, and word 2 starts on the edge after its acceptance.
- RST_N pulled low at cycle 30 of bit 5: LED_SIG=0 immediately; after release PIX_READY stays low one cycle and nothing is transmitted without a new handshake.
- PIX_VALID high during LATCH: no acceptance until LATCH ends; the word then starts 1 cycle after PIX_READY is seen high.
- Build with LED_BIT_SERIALIZER_INV_EN and rerun test 1: the waveform is the exact bitwise complement.

Source files
------------

// File: rtl/ledlines_pkg.sv
// Shared constants and FSM encoding for the LEDLines serial output stage.
// All timing values are clock cycles of the 50 MHz system clock (20 ns).
package ledlines_pkg;

    localparam int DATA_WIDTH = 24;    // GRB pixel word, shifted MSB first
    localparam int T_BIT      = 63;    // 1.26 us bit period
    localparam int T0H        = 20;    // 0.40 us high time for a 0 bit
    localparam int T1H        = 40;    // 0.80 us high time for a 1 bit
    localparam int T_LATCH    = 2600;  // 52 us low time closing a frame

    localparam int CYC_W = $clog2(T_LATCH);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

endpackage

// File: rtl/led_bit_serializer.sv
// Serialises GRB pixel words MSB-first onto one WS2812-style line with pulse-width coding.
// Define LED_BIT_SERIALIZER_INV_EN to invert the line for inverting level shifters.
module led_bit_serializer
    import ledlines_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] PIX_DATA,
    input  logic                  PIX_LAST,
    input  logic                  PIX_VALID,
    output logic                  PIX_READY,
    output logic                  LED_SIG,
    output logic                  BUSY,
    output logic                  UNDERRUN,
    output state_t                STATE_DBG
);

    if (T1H >= T_BIT || T0H >= T1H || T0H == 0) begin : g_bad_timing
        $error("led_bit_serializer: bit timing needs 0 < T0H < T1H < T_BIT");
    end

`ifdef LED_BIT_SERIALIZER_INV_EN
    localparam logic LED_REST = 1'b1;
`else
    localparam logic LED_REST = 1'b0;
`endif

    localparam logic [CYC_W-1:0] CYC_BIT_END   = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] CYC_T0H_END   = CYC_W'(T0H - 1);
    localparam logic [CYC_W-1:0] CYC_T1H_END   = CYC_W'(T1H - 1);
    localparam logic [CYC_W-1:0] CYC_LATCH_END = CYC_W'(T_LATCH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_WIDTH - 1);

    state_t                state, state_n;
    logic [CYC_W-1:0]      cyc, cyc_n;
    logic [IDX_W-1:0]      bit_idx, bit_idx_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  last_q, last_n;
    logic                  underrun_q, underrun_n;
    logic                  rst_done;
    logic                  led_q;
    logic                  word_end;
    logic                  accept;
    logic [CYC_W-1:0]      thi_end;

    // Handshake: a word transfers on a rising edge where PIX_VALID and PIX_READY are both high;
    // PIX_READY never depends on PIX_VALID, and PIX_DATA/PIX_LAST are only sampled on transfer.
    assign word_end  = (state == ST_LOW) && (bit_idx == IDX_LAST) && (cyc == CYC_BIT_END);
    assign PIX_READY = rst_done && ((state == ST_IDLE) || (word_end && !last_q));
    assign accept    = PIX_VALID && PIX_READY;
    assign thi_end   = shreg[DATA_WIDTH-1] ? CYC_T1H_END : CYC_T0H_END;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            cyc        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
            rst_done   <= 1'b0;
            led_q      <= LED_REST;
        end else begin
            state      <= state_n;
            cyc        <= cyc_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            last_q     <= last_n;
            underrun_q <= underrun_n;
            rst_done   <= 1'b1;
            // Driven from the current state so the line rises one edge after acceptance.
            led_q      <= (state == ST_HIGH) ^ LED_REST;
        end
    end

    always_comb begin
        state_n    = state;
        cyc_n      = cyc;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        last_n     = last_q;
        underrun_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n   = ST_HIGH;
                    cyc_n     = '0;
                    bit_idx_n = '0;
                    shreg_n   = PIX_DATA;
                    last_n    = PIX_LAST;
                end
            end
            ST_HIGH: begin
                // cyc keeps counting into LOW so one counter spans the whole bit period.
                cyc_n = cyc + CYC_W'(1);
                if (cyc == thi_end) begin
                    state_n = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cyc != CYC_BIT_END) begin
                    cyc_n = cyc + CYC_W'(1);
                end else if (bit_idx != IDX_LAST) begin
                    state_n   = ST_HIGH;
                    cyc_n     = '0;
                    bit_idx_n = bit_idx + IDX_W'(1);
                    shreg_n   = shreg << 1;
                end else if (last_q) begin
                    state_n = ST_LATCH;
                    cyc_n   = '0;
                end else if (accept) begin
                    state_n   = ST_HIGH;
                    cyc_n     = '0;
                    bit_idx_n = '0;
                    shreg_n   = PIX_DATA;
                    last_n    = PIX_LAST;
                end else begin
                    state_n    = ST_IDLE;
                    cyc_n      = '0;
                    bit_idx_n  = '0;
                    underrun_n = 1'b1;
                end
            end
            ST_LATCH: begin
                if (cyc == CYC_LATCH_END) begin
                    state_n = ST_IDLE;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign LED_SIG   = led_q;
    assign BUSY      = (state != ST_IDLE);
    assign UNDERRUN  = underrun_q;
    assign STATE_DBG = state;

endmodule
